// File: rtl/vram_arbiter.sv
// Purpose: one single-port VRAM shared by scanout (absolute priority) and two round-robin draw requesters; DOUBLE_BUF_EN adds front/back buffer swap.
// Latency: the granted command is on o_mem_* one cycle after o_gnt, and read data/valid arrive two cycles after it.
// Backpressure: draw requesters hold i_req until they see o_gnt; scanout is never stalled.
module vram_arbiter #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 18,
    parameter int PIX_COUNT = 230400
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pix_stb,
    input  logic              i_active,
    input  logic              i_screenend,
    input  logic [1:0]        i_req,
    input  logic [1:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic [1:0]        o_gnt,
    output logic [1:0]        o_drd_valid,
    output logic [DATA_W-1:0] o_drd_data,
    output logic              o_pix_valid,
    output logic [DATA_W-1:0] o_pix_data,
    input  logic              i_swap,
    output logic              o_swap_pend,
    output logic              o_swap_done,
    output logic              o_front,
`ifdef DOUBLE_BUF_EN
    output logic [ADDR_W:0]   o_mem_addr,
`else
    output logic [ADDR_W-1:0] o_mem_addr,
`endif
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

`ifdef DOUBLE_BUF_EN
    localparam int MEM_AW = ADDR_W + 1;
`else
    localparam int MEM_AW = ADDR_W;
`endif
    localparam logic [ADDR_W-1:0] SCAN_LAST = ADDR_W'(PIX_COUNT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAW0, DRAW1} owner_t;

    owner_t              owner;
    owner_t              cmd_owner;
    logic                rr_ptr;
    logic [ADDR_W-1:0]   scan_addr;
    logic [MEM_AW-1:0]   nxt_addr;
    logic                nxt_we;
    logic [DATA_W-1:0]   nxt_wdata;
    logic [DATA_W-1:0]   pix_hold;
    logic [DATA_W-1:0]   drd_hold;

    // cmd_owner remembers who owns the command now on o_mem_*, to steer its read data
    always_ff @(posedge i_clk) begin
        if (i_rst) cmd_owner <= IDLE;
        else       cmd_owner <= owner;
    end

    always_comb begin
        owner = IDLE;
        if (i_pix_stb && i_active)  owner = SCAN;
        else if (i_req[rr_ptr])     owner = rr_ptr ? DRAW1 : DRAW0;
        else if (i_req[!rr_ptr])    owner = rr_ptr ? DRAW0 : DRAW1;
        o_gnt = {owner == DRAW1, owner == DRAW0};
    end

    always_comb begin
        nxt_addr  = '0;
        nxt_we    = 1'b0;
        nxt_wdata = '0;
        case (owner)
            SCAN:  nxt_addr = MEM_AW'(scan_addr);
            DRAW0: begin
                nxt_addr  = MEM_AW'(i_addr0);
                nxt_we    = i_we[0];
                nxt_wdata = i_wdata0;
            end
            DRAW1: begin
                nxt_addr  = MEM_AW'(i_addr1);
                nxt_we    = i_we[1];
                nxt_wdata = i_wdata1;
            end
            default: ;
        endcase
`ifdef DOUBLE_BUF_EN
        // scanout reads the front buffer, drawing targets the back buffer
        if (owner == SCAN)                        nxt_addr[ADDR_W] = o_front;
        else if (owner == DRAW0 || owner == DRAW1) nxt_addr[ADDR_W] = ~o_front;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr      <= 1'b0;
            scan_addr   <= '0;
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
            o_pix_valid <= 1'b0;
            o_drd_valid <= 2'b00;
            pix_hold    <= '0;
            drd_hold    <= '0;
        end else begin
            o_mem_addr  <= nxt_addr;
            o_mem_we    <= nxt_we;
            o_mem_wdata <= nxt_wdata;
            if (owner == DRAW0)      rr_ptr <= 1'b1;
            else if (owner == DRAW1) rr_ptr <= 1'b0;
            if (i_screenend)
                scan_addr <= '0;
            else if (owner == SCAN && scan_addr != SCAN_LAST)
                scan_addr <= scan_addr + 1'b1;
            o_pix_valid <= (cmd_owner == SCAN);
            o_drd_valid <= {cmd_owner == DRAW1 && !o_mem_we, cmd_owner == DRAW0 && !o_mem_we};
            if (o_pix_valid)  pix_hold <= i_mem_rdata;
            if (|o_drd_valid) drd_hold <= i_mem_rdata;
        end
    end

    // RAM data lands in the valid cycle itself; the hold registers keep it until the next read
    assign o_pix_data = o_pix_valid  ? i_mem_rdata : pix_hold;
    assign o_drd_data = |o_drd_valid ? i_mem_rdata : drd_hold;

`ifdef DOUBLE_BUF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_front     <= 1'b0;
            o_swap_pend <= 1'b0;
            o_swap_done <= 1'b0;
        end else begin
            o_swap_done <= 1'b0;
            if (i_screenend && (o_swap_pend || i_swap)) begin
                o_front     <= ~o_front;
                o_swap_pend <= 1'b0;
                o_swap_done <= 1'b1;
            end else if (i_swap) begin
                o_swap_pend <= 1'b1;
            end
        end
    end
`else
    logic unused_swap;
    assign unused_swap = i_swap;
    assign o_front     = 1'b0;
    assign o_swap_pend = 1'b0;
    assign o_swap_done = 1'b0;
`endif

endmodule
